dcc_packet_scheduler: RTL



---
 rtl/dcc_pkg.sv | 28 ++
 rtl/dcc_ack_sync.sv | 29 ++
 rtl/dcc_packet_scheduler.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dcc_pkg.sv
// Shared types and constants for the DCC packet scheduler.
package dcc_pkg;

  // Framing states of one DCC packet on the track.
  typedef enum logic [1:0] {
    PREAMBLE = 2'd0,
    SEP      = 2'd1,
    BYTE     = 2'd2,
    END      = 2'd3
  } dcc_state_t;

  // Idle packet contents; its error byte is the XOR of the two data bytes.
  localparam logic [7:0] IDLE_B0  = 8'hFF;
  localparam logic [7:0] IDLE_B1  = 8'h00;
  localparam logic [7:0] IDLE_ERR = IDLE_B0 ^ IDLE_B1;

  // Shortest and longest preamble the counter is built for.
  localparam int unsigned PREAMBLE_MIN = 14;
  localparam int unsigned PREAMBLE_MAX = 31;

  // Counter and field widths.
  localparam int PRE_CNT_W  = 5;  // holds 0..PREAMBLE_MAX-1
  localparam int BIT_CNT_W  = 3;  // bit within a byte, 0..7
  localparam int BYTE_IDX_W = 3;  // data bytes plus the error byte
  localparam int LEN_W      = 3;  // pkt_len field
  localparam int REP_W      = 4;  // pkt_repeat field

endpackage

// File: rtl/dcc_ack_sync.sv
// Brings the encoder ack into the clk domain and turns each rising edge
// into a single-cycle advance strobe.
module dcc_ack_sync (
  input  logic clk,
  input  logic reset,
  input  logic ack_in,
  output logic adv
);

  logic sync_q1;
  logic sync_q2;
  logic ack_prev_q;

  // Two-flop synchronizer followed by one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      ack_prev_q <= 1'b0;
    end else begin
      sync_q1    <= ack_in;
      sync_q2    <= sync_q1;
      ack_prev_q <= sync_q2;
    end
  end

  assign adv = sync_q2 & ~ack_prev_q;

endmodule

// File: rtl/dcc_packet_scheduler.sv
// Frames host command packets (or the idle packet) into a DCC bit stream,
// one bit per encoder ack.
//
// Host handshake: a packet transfers on a clk edge where pkt_valid and
// pkt_ready are both high; the host holds pkt_len/pkt_data/pkt_repeat stable
// while pkt_valid is high, and pkt_ready depends only on internal state.
module dcc_packet_scheduler
  import dcc_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 16,
  parameter int unsigned MAX_BYTES    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  input  logic [2:0]             pkt_len,
  input  logic [8*MAX_BYTES-1:0] pkt_data,
  input  logic [3:0]             pkt_repeat,
  input  logic                   enc_ack,
  output logic                   enc_bit,
  output logic                   pkt_done,
  output logic                   pkt_err,
  output logic                   idle_active
);

  // Out-of-range preamble lengths are clamped to what the counter supports.
  localparam int unsigned PRE_LEN_EFF =
    (PREAMBLE_LEN < PREAMBLE_MIN) ? PREAMBLE_MIN :
    (PREAMBLE_LEN > PREAMBLE_MAX) ? PREAMBLE_MAX : PREAMBLE_LEN;
  localparam logic [PRE_CNT_W-1:0] PRE_LAST = PRE_CNT_W'(PRE_LEN_EFF - 1);
  localparam logic [LEN_W-1:0]     MAX_LEN  = LEN_W'(MAX_BYTES);
  localparam int                   DATA_W   = 8 * MAX_BYTES;

  logic adv;

  dcc_state_t state_q;
  dcc_state_t state_d;

  logic [PRE_CNT_W-1:0]  pre_cnt_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic [BYTE_IDX_W-1:0] byte_idx_q;

  // Holding register (one entry from the host).
  logic              hold_full_q;
  logic [DATA_W-1:0] hold_data_q;
  logic [LEN_W-1:0]  hold_len_q;
  logic [REP_W-1:0]  hold_rep_q;

  // Active buffer (packet currently on the track).
  logic              act_loaded_q;
  logic              act_host_q;
  logic [DATA_W-1:0] act_data_q;
  logic [LEN_W-1:0]  act_len_q;
  logic [REP_W-1:0]  act_rep_q;
  logic [7:0]        act_err_q;

  logic              pre_last;
  logic              bit_last;
  logic              on_err_byte;
  logic              boundary;
  logic              first_load;
  logic              take_next;
  logic              accept;
  logic              len_ok;
  logic [7:0]        cur_byte;
  logic [7:0]        hold_xor;
  logic [DATA_W-1:0] idle_data;

  dcc_ack_sync u_ack_sync (
    .clk    (clk),
    .reset  (reset),
    .ack_in (enc_ack),
    .adv    (adv)
  );

  assign pkt_ready = ~hold_full_q;
  assign accept    = pkt_valid & pkt_ready;
  assign len_ok    = (pkt_len != '0) && (pkt_len <= MAX_LEN);

  // Framing state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PREAMBLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next framing state, the bit presented to the encoder and load strobes.
  always_comb begin
    state_d     = state_q;
    enc_bit     = 1'b1;
    pre_last    = (pre_cnt_q == PRE_LAST);
    bit_last    = (bit_cnt_q == 3'd7);
    on_err_byte = (byte_idx_q == act_len_q);
    boundary    = 1'b0;
    first_load  = 1'b0;
    case (state_q)
      PREAMBLE: begin
        enc_bit = 1'b1;
        if (adv && pre_last) begin
          state_d    = SEP;
          // Right after reset nothing is active yet: pick the first packet here.
          first_load = ~act_loaded_q;
        end
      end
      SEP: begin
        enc_bit = 1'b0;
        if (adv) state_d = BYTE;
      end
      BYTE: begin
        enc_bit = cur_byte[~bit_cnt_q];
        if (adv && bit_last) state_d = on_err_byte ? END : SEP;
      end
      END: begin
        enc_bit = 1'b1;
        if (adv) begin
          state_d  = PREAMBLE;
          boundary = 1'b1;
        end
      end
      default: state_d = PREAMBLE;
    endcase
    take_next = (boundary && (act_rep_q == '0)) || first_load;
  end

  // Select the byte being shifted out: a data byte, or the error byte last.
  always_comb begin
    cur_byte = act_err_q;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if ((byte_idx_q == BYTE_IDX_W'(i)) && (byte_idx_q < act_len_q)) begin
        cur_byte = act_data_q[i*8 +: 8];
      end
    end
  end

  // Error byte of the held packet and the fixed idle packet image.
  always_comb begin
    hold_xor  = 8'h00;
    idle_data = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (LEN_W'(i) < hold_len_q) hold_xor = hold_xor ^ hold_data_q[i*8 +: 8];
    end
    idle_data[7:0]  = IDLE_B0;
    idle_data[15:8] = IDLE_B1;
  end

  // Preamble, bit and byte counters, stepped once per encoder advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
    end else if (adv) begin
      case (state_q)
        PREAMBLE: pre_cnt_q <= pre_last ? '0 : pre_cnt_q + 1'b1;
        BYTE: begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_last) byte_idx_q <= byte_idx_q + 1'b1;
        end
        END: begin
          byte_idx_q <= '0;
          pre_cnt_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Holding register, active buffer, repeat handling and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full_q  <= 1'b0;
      hold_data_q  <= '0;
      hold_len_q   <= '0;
      hold_rep_q   <= '0;
      act_loaded_q <= 1'b0;
      act_host_q   <= 1'b0;
      act_data_q   <= '0;
      act_len_q    <= '0;
      act_rep_q    <= '0;
      act_err_q    <= '0;
      idle_active  <= 1'b0;
      pkt_done     <= 1'b0;
      pkt_err      <= 1'b0;
    end else begin
      pkt_done <= boundary && act_host_q && (act_rep_q == '0);
      pkt_err  <= accept && !len_ok;

      // A handshake only happens with the holding register empty, so it never
      // collides with the hold-to-active move below.
      if (accept && len_ok) begin
        hold_full_q <= 1'b1;
        hold_data_q <= pkt_data;
        hold_len_q  <= pkt_len;
        hold_rep_q  <= pkt_repeat;
      end

      if (take_next) begin
        act_loaded_q <= 1'b1;
        if (hold_full_q) begin
          hold_full_q <= 1'b0;
          act_host_q  <= 1'b1;
          act_data_q  <= hold_data_q;
          act_len_q   <= hold_len_q;
          act_rep_q   <= hold_rep_q;
          act_err_q   <= hold_xor;
          idle_active <= 1'b0;
        end else begin
          act_host_q  <= 1'b0;
          act_data_q  <= idle_data;
          act_len_q   <= LEN_W'(2);
          act_rep_q   <= '0;
          act_err_q   <= IDLE_ERR;
          idle_active <= 1'b1;
        end
      end else if (boundary) begin
        act_rep_q <= act_rep_q - 1'b1;
      end
    end
  end

endmodule
